// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states, MIPS opcodes,
// and the mux/ALU select codes the datapath and ALU control also decode.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main multicycle CPU control FSM: Moore decode of every mux select and write
// enable, with stall freezing the sequence and rst gating all outputs to zero.
module multicycle_control
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       stall,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op
);

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        if (is_mem_op(opcode))        state_d = S_MEMADDR;
        else if (opcode == OP_RTYPE)  state_d = S_EXECUTE;
        else if (opcode == OP_BEQ)    state_d = S_BRANCH;
        else if (opcode == OP_J)      state_d = S_JUMP;
        else if (opcode == OP_ADDI)   state_d = S_ADDI_EX;
        else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (opcode == OP_SW) state_d = S_MEMWRITE;
        else                 state_d = S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Stall freezes the sequence; selects stay valid so the datapath sees no glitch.
    if (stall) begin
      state_d       = state_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      mem_read      = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
    end

    if (rst) begin
      state_d       = S_FETCH;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALU_ADD;
      pc_source     = PCSRC_ALU;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: the driver walks each instruction's step list and queues the
// expected output word per cycle; a negedge monitor pops and compares.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       stall = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .stall(stall),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef enum int {P_F, P_D, P_D_ILL, P_MA, P_MR, P_MWB, P_MW, P_EX, P_RWB, P_BR, P_J, P_AEX, P_AWB} phase_e;

  typedef struct packed {
    logic [17:0] word;
    logic [5:0]  op;
    int          step;
  } exp_t;

  exp_t   exp_q[$];
  phase_e steps_q[$];
  int     n_vec = 0;
  int     n_bad = 0;
  int     cyc   = 0;

  // Word order: pw pwc iod mr mw irw m2r rdst rw asa srcb[2] aluop[2] pcsrc[2] done ill
  function automatic logic [17:0] expect_word(input phase_e p, input logic stl);
    logic pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, dn, ill;
    logic [1:0] sb, ao, ps;
    {pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, dn, ill} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (p)
      P_F:     begin mr = 1; irw = 1; sb = 2'b01; pw = 1; end
      P_D:     sb = 2'b11;
      P_D_ILL: begin sb = 2'b11; ill = 1; end
      P_MA:    begin asa = 1; sb = 2'b10; end
      P_AEX:   begin asa = 1; sb = 2'b10; end
      P_MR:    begin mr = 1; iod = 1; end
      P_MWB:   begin rw = 1; m2r = 1; dn = 1; end
      P_MW:    begin mw = 1; iod = 1; dn = 1; end
      P_EX:    begin asa = 1; ao = 2'b10; end
      P_RWB:   begin rdst = 1; rw = 1; dn = 1; end
      P_AWB:   begin rw = 1; dn = 1; end
      P_BR:    begin asa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; dn = 1; end
      P_J:     begin pw = 1; ps = 2'b10; dn = 1; end
      default: ;
    endcase
    if (stl) {pw, pwc, irw, rw, mw, mr, dn, ill} = '0;
    return {pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, sb, ao, ps, dn, ill};
  endfunction

  function automatic void build_steps(input logic [5:0] op);
    steps_q.delete();
    steps_q.push_back(P_F);
    case (op)
      6'b100011: begin steps_q.push_back(P_D); steps_q.push_back(P_MA); steps_q.push_back(P_MR); steps_q.push_back(P_MWB); end
      6'b101011: begin steps_q.push_back(P_D); steps_q.push_back(P_MA); steps_q.push_back(P_MW); end
      6'b000000: begin steps_q.push_back(P_D); steps_q.push_back(P_EX); steps_q.push_back(P_RWB); end
      6'b001000: begin steps_q.push_back(P_D); steps_q.push_back(P_AEX); steps_q.push_back(P_AWB); end
      6'b000100: begin steps_q.push_back(P_D); steps_q.push_back(P_BR); end
      6'b000010: begin steps_q.push_back(P_D); steps_q.push_back(P_J); end
      default:   steps_q.push_back(P_D_ILL);
    endcase
  endfunction

  // Runs one instruction; stall_len forced stall cycles at step stall_step, reset at cycle rst_cyc.
  task automatic run_instr(input logic [5:0] op, input int stall_pct,
                           input int stall_step, input int stall_len, input int rst_cyc);
    int pos, c, left;
    logic stl, r;
    exp_t e;
    build_steps(op);
    pos = 0; c = 0; left = stall_len;
    opcode = op;
    while (pos < steps_q.size()) begin
      if (pos == stall_step && left > 0) begin
        stl = 1'b1; left--;
      end else begin
        stl = ($urandom_range(99) < stall_pct);
      end
      r = (c == rst_cyc);
      stall = stl;
      rst   = r;
      e.op   = op;
      e.step = pos;
      e.word = r ? 18'd0 : expect_word(steps_q[pos], stl);
      exp_q.push_back(e);
      @(posedge clk); #1;
      if (r) break;
      if (!stl) pos++;
      c++;
    end
    rst = 1'b0;
    stall = 1'b0;
  endtask

  task automatic reset_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      rst = 1'b1;
      stall = ($urandom_range(1) == 1);
      e.op = opcode; e.step = -1; e.word = 18'd0;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    stall = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [17:0] got;
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op};
      n_vec++;
      if (got !== e.word) begin
        n_bad++;
        $display("FAIL ctrl_word cyc=%0d op=%b step=%0d rst=%b stall=%b got=%b exp=%b",
                 cyc, e.op, e.step, rst, stall, got, e.word);
      end else begin
        $display("ok   cyc=%0d op=%b step=%0d word=%b", cyc, e.op, e.step, got);
      end
    end
  end

  localparam logic [5:0] OPS [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};

  initial begin
    logic [5:0] op;
    int rc;
    @(posedge clk); #1;
    reset_cycles(2);
    run_instr(6'b100011, 0, -1, 0, -1);  // lw, 5 cycles
    run_instr(6'b000000, 0, -1, 0, -1);  // R-type
    run_instr(6'b001000, 0, -1, 0, -1);  // addi
    run_instr(6'b000100, 0, -1, 0, -1);  // beq
    run_instr(6'b000010, 0, -1, 0, -1);  // j
    run_instr(6'b111111, 0, -1, 0, -1);  // illegal
    run_instr(6'b101011, 0, 3, 3, -1);   // sw stalled 3 cycles in MEMWRITE
    run_instr(6'b100011, 0, -1, 0, 3);   // lw reset in MEMREAD
    run_instr(6'b010101, 0, 1, 2, -1);   // illegal stalled in DECODE
    run_instr(6'b000000, 0, 0, 2, -1);   // stall in FETCH
    run_instr(6'b101011, 0, 2, 1, 2);    // reset while stalled in MEMADDR
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(9) == 0) op = 6'($urandom_range(63));
      else                        op = OPS[$urandom_range(5)];
      rc = ($urandom_range(19) == 0) ? int'($urandom_range(6)) : -1;
      run_instr(op, 20, -1, 0, rc);
    end
    run_instr(6'b100011, 0, -1, 0, -1);
    @(negedge clk); #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
